// File: rtl/instruction_decode_stage_if.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage_if
// Bundles the upstream instruction handshake, the downstream decoded-instruction
// handshake, the flush request and the accepted-instruction counter of the
// instruction decode stage.
//   master : the surroundings (fetch side drives instructions and flush,
//            execute side drives out_ready)
//   slave  : the decode stage itself
// Ports carried:
//   flush, in_valid, in_ready, in_instr, in_pc_plus4,
//   out_valid, out_ready, out_opcode, out_rs, out_rt, out_rd, out_shamt,
//   out_funct, out_imm_ext, out_jump_target, out_pc_plus4, out_type,
//   accept_count
// -----------------------------------------------------------------------------
interface instruction_decode_stage_if #(
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [MEM_WIDTH-1:0]  in_instr;
  logic [ADDR_WIDTH-1:0] in_pc_plus4;
  logic                  out_valid;
  logic                  out_ready;
  logic [5:0]            out_opcode;
  logic [4:0]            out_rs;
  logic [4:0]            out_rt;
  logic [4:0]            out_rd;
  logic [4:0]            out_shamt;
  logic [5:0]            out_funct;
  logic [DATA_WIDTH-1:0] out_imm_ext;
  logic [ADDR_WIDTH-1:0] out_jump_target;
  logic [ADDR_WIDTH-1:0] out_pc_plus4;
  logic [1:0]            out_type;
  logic [CNT_WIDTH-1:0]  accept_count;

  modport master (
    output flush, in_valid, in_instr, in_pc_plus4, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm_ext, out_jump_target, out_pc_plus4, out_type,
           accept_count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc_plus4, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm_ext, out_jump_target, out_pc_plus4, out_type,
           accept_count
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage
// MIPS32 instruction decode stage with a two-entry elastic buffer.
// Incoming words are decoded combinationally and the decoded record is stored
// in a head register (which drives every out_* field) or, when the head is
// occupied and not leaving, in a skid register. in_ready is a registered
// "skid empty" flag, so upstream never sees a combinational path from
// out_ready. flush empties both entries; accept_count counts accepted words.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : instruction_decode_stage_if.slave (handshakes, fields, counter)
// -----------------------------------------------------------------------------
module instruction_decode_stage #(
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  instruction_decode_stage_if.slave    bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  typedef struct packed {
    logic [5:0]            opcode;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [1:0]            itype;
  } dec_t;

  // Full field decode of one instruction word.
  function automatic dec_t decode(input logic [MEM_WIDTH-1:0]  instr,
                                  input logic [ADDR_WIDTH-1:0] pc_plus4);
    dec_t d;
    d          = '0;
    d.opcode   = instr[31:26];
    d.rs       = instr[25:21];
    d.rt       = instr[20:16];
    d.rd       = instr[15:11];
    d.shamt    = instr[10:6];
    d.funct    = instr[5:0];
    d.pc_plus4 = pc_plus4;
    // Jump target keeps the PC+4 region above bit 27 and replaces the low
    // 28 bits with the word-aligned 26-bit index.
    d.jump_target = (pc_plus4 & ~ADDR_WIDTH'(28'hFFF_FFFF))
                  | ADDR_WIDTH'({instr[25:0], 2'b00});
    case (instr[31:26])
      OP_ANDI, OP_ORI, OP_XORI: d.imm_ext = DATA_WIDTH'(instr[15:0]);
      default:                  d.imm_ext = DATA_WIDTH'($signed(instr[15:0]));
    endcase
    case (instr[31:26])
      OP_SPECIAL:   d.itype = TYPE_R;
      OP_J, OP_JAL: d.itype = TYPE_J;
      default:      d.itype = TYPE_I;
    endcase
    return d;
  endfunction

  dec_t                 head_r;
  dec_t                 skid_r;
  logic                 head_valid_r;
  logic                 skid_valid_r;
  logic                 in_ready_r;
  logic [CNT_WIDTH-1:0] accept_count_r;

  dec_t head_s;
  dec_t skid_s;
  dec_t dec_s;
  logic head_valid_s;
  logic skid_valid_s;
  logic accept_s;
  logic consume_s;

  assign dec_s     = decode(bus.in_instr, bus.in_pc_plus4);
  assign accept_s  = bus.in_valid & in_ready_r & ~bus.flush;
  assign consume_s = head_valid_r & bus.out_ready;

  // Next-state of the two-entry buffer; flush empties both entries.
  always_comb begin
    head_s       = head_r;
    skid_s       = skid_r;
    head_valid_s = head_valid_r;
    skid_valid_s = skid_valid_r;
    if (bus.flush) begin
      head_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (consume_s) begin
      if (skid_valid_r) begin
        // Skid advances into the head; a concurrent accept refills the skid.
        head_s       = skid_r;
        head_valid_s = 1'b1;
        if (accept_s) begin
          skid_s       = dec_s;
          skid_valid_s = 1'b1;
        end else begin
          skid_valid_s = 1'b0;
        end
      end else begin
        if (accept_s) begin
          head_s       = dec_s;
          head_valid_s = 1'b1;
        end else begin
          head_valid_s = 1'b0;
        end
      end
    end else begin
      if (accept_s) begin
        if (head_valid_r) begin
          // in_ready was high, so the skid is known to be empty here.
          skid_s       = dec_s;
          skid_valid_s = 1'b1;
        end else begin
          head_s       = dec_s;
          head_valid_s = 1'b1;
        end
      end else begin
        head_valid_s = head_valid_r;
      end
    end
  end

  // Buffer state, registered ready flag and accept counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r         <= '0;
      skid_r         <= '0;
      head_valid_r   <= 1'b0;
      skid_valid_r   <= 1'b0;
      in_ready_r     <= 1'b1;
      accept_count_r <= '0;
    end else begin
      head_r       <= head_s;
      skid_r       <= skid_s;
      head_valid_r <= head_valid_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= ~skid_valid_s;
      if (accept_s) begin
        accept_count_r <= accept_count_r + CNT_WIDTH'(1);
      end else begin
        accept_count_r <= accept_count_r;
      end
    end
  end

  assign bus.in_ready        = in_ready_r;
  assign bus.out_valid       = head_valid_r;
  assign bus.out_opcode      = head_r.opcode;
  assign bus.out_rs          = head_r.rs;
  assign bus.out_rt          = head_r.rt;
  assign bus.out_rd          = head_r.rd;
  assign bus.out_shamt       = head_r.shamt;
  assign bus.out_funct       = head_r.funct;
  assign bus.out_imm_ext     = head_r.imm_ext;
  assign bus.out_jump_target = head_r.jump_target;
  assign bus.out_pc_plus4    = head_r.pc_plus4;
  assign bus.out_type        = head_r.itype;
  assign bus.accept_count    = accept_count_r;

endmodule
